// File: rtl/bingo_call_marker.sv
// bingo_call_marker
// Turns keypad presses into two-digit called numbers, rejects bad or repeated
// calls, marks them on a fixed 15-number card and reports line/bingo status.
//
// Ports:
//   i_clk          system clock
//   i_rstn         asynchronous active-low reset
//   i_start_game   game-running level from the keyboard controller
//   i_num_count    keyboard press counter; any change is one press
//   i_cascade_reg  [7:4] previous key, [3:0] newest key
//   o_mark_mask    bit i set when card entry i has been called
//   o_line         bit r set when all five entries of row r are marked
//   o_bingo        all 15 entries marked (sticky)
//   o_last_num     last accepted called number
//   o_call_count   number of accepted calls
//   o_range_err    one-cycle pulse: bad digit or out-of-range value
//   o_dup_err      one-cycle pulse: number already called
//   o_overrun      one-cycle pulse: press dropped while busy
module bingo_call_marker #(
  parameter int unsigned  MAX_NUM = 90,
  parameter logic [104:0] CARD    = 105'h0
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_start_game,
  input  logic [1:0]  i_num_count,
  input  logic [7:0]  i_cascade_reg,
  output logic [14:0] o_mark_mask,
  output logic [2:0]  o_line,
  output logic        o_bingo,
  output logic [6:0]  o_last_num,
  output logic [6:0]  o_call_count,
  output logic        o_range_err,
  output logic        o_dup_err,
  output logic        o_overrun
);

  localparam logic [6:0] MaxNum = 7'(MAX_NUM);

  typedef enum logic [2:0] {
    StIdle,
    StWaitD1,
    StWaitD2,
    StCheck,
    StCommit,
    StDone
  } state_e;

  state_e r_state;
  state_e w_state_next;

  logic [1:0]       r_nc;
  logic [3:0]       r_tens;
  logic [3:0]       r_units;
  logic [MAX_NUM:1] r_called;
  logic [14:0]      r_mark_mask;
  logic [2:0]       r_line;
  logic             r_bingo;
  logic [6:0]       r_last_num;
  logic [6:0]       r_call_count;
  logic             r_range_err;
  logic             r_dup_err;
  logic             r_overrun;

  logic        w_press;
  logic [6:0]  w_val;
  logic        w_range_bad;
  logic        w_dup;
  logic [14:0] w_match;
  logic        w_latch;
  logic        w_accept;
  logic        w_range_pulse;
  logic        w_dup_pulse;
  logic        w_overrun_pulse;
  logic        w_status_upd;

  // The start key's own press lands while start_game is still low, so it is ignored here.
  assign w_press = i_start_game && (i_num_count != r_nc);

  // Digits above 9 are rejected below, so wrap-around of this sum never matters.
  assign w_val       = ({3'b000, r_tens} * 7'd10) + {3'b000, r_units};
  assign w_range_bad = (r_tens > 4'd9) || (r_units > 4'd9) || (w_val == 7'd0) ||
                       (w_val > MaxNum);
  assign w_dup       = r_called[w_val];

  // Card entries of 0 or above MAX_NUM can never match a legal call.
  always_comb begin
    logic [6:0] w_entry;
    w_match = '0;
    w_entry = '0;
    for (int i = 0; i < 15; i++) begin
      w_entry    = CARD[7*i +: 7];
      w_match[i] = (w_entry == w_val) && (w_entry != 7'd0) && (w_entry <= MaxNum);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_latch         = 1'b0;
    w_accept        = 1'b0;
    w_range_pulse   = 1'b0;
    w_dup_pulse     = 1'b0;
    w_overrun_pulse = 1'b0;
    w_status_upd    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start_game) w_state_next = StWaitD1;
      end
      StWaitD1: begin
        if (w_press) w_state_next = StWaitD2;
      end
      StWaitD2: begin
        if (w_press) begin
          if (i_cascade_reg[3:0] == 4'hA) begin
            w_state_next = StWaitD1;
          end else begin
            w_latch      = 1'b1;
            w_state_next = StCheck;
          end
        end
      end
      StCheck: begin
        w_overrun_pulse = w_press;
        if (w_range_bad) begin
          w_range_pulse = 1'b1;
          w_state_next  = StWaitD1;
        end else if (w_dup) begin
          w_dup_pulse  = 1'b1;
          w_state_next = StWaitD1;
        end else begin
          w_accept     = 1'b1;
          w_state_next = StCommit;
        end
      end
      StCommit: begin
        // The mask already holds this call, so it can decide DONE directly.
        w_overrun_pulse = w_press;
        w_status_upd    = 1'b1;
        w_state_next    = (&r_mark_mask) ? StDone : StWaitD1;
      end
      StDone: begin
        w_state_next = StDone;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
    // Dropping start_game abandons any partial pair from every state.
    if (!i_start_game) begin
      w_state_next  = StIdle;
      w_latch       = 1'b0;
      w_accept      = 1'b0;
      w_range_pulse = 1'b0;
      w_dup_pulse   = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_nc         <= '0;
      r_tens       <= '0;
      r_units      <= '0;
      r_called     <= '0;
      r_mark_mask  <= '0;
      r_line       <= '0;
      r_bingo      <= 1'b0;
      r_last_num   <= '0;
      r_call_count <= '0;
      r_range_err  <= 1'b0;
      r_dup_err    <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_nc        <= i_num_count;
      r_range_err <= w_range_pulse;
      r_dup_err   <= w_dup_pulse;
      r_overrun   <= w_overrun_pulse;
      if (w_latch) begin
        r_tens  <= i_cascade_reg[7:4];
        r_units <= i_cascade_reg[3:0];
      end
      // Results become visible in the same cycle an error pulse would.
      if (w_accept) begin
        r_called[w_val] <= 1'b1;
        r_last_num      <= w_val;
        r_mark_mask     <= r_mark_mask | w_match;
        if (r_call_count != MaxNum) r_call_count <= r_call_count + 7'd1;
      end
      if (w_status_upd) begin
        r_line[0] <= &r_mark_mask[4:0];
        r_line[1] <= &r_mark_mask[9:5];
        r_line[2] <= &r_mark_mask[14:10];
        r_bingo   <= r_bingo | (&r_mark_mask);
      end
    end
  end

  assign o_mark_mask  = r_mark_mask;
  assign o_line       = r_line;
  assign o_bingo      = r_bingo;
  assign o_last_num   = r_last_num;
  assign o_call_count = r_call_count;
  assign o_range_err  = r_range_err;
  assign o_dup_err    = r_dup_err;
  assign o_overrun    = r_overrun;

endmodule

// File: doc/bingo_call_marker.md
Name: bingo_call_marker

Overview:
- Sits directly downstream of the keyboard controller. It consumes start_game, num_count and the 8-bit cascade digit register.
- Assembles two-digit called numbers, validates them and rejects repeats, marks them against a fixed 15-number player card, and flags line/bingo completion.
- Outputs drive the display and status LED stages.

Parameters:
- MAX_NUM, 90, highest legal called number; legal range is 1..MAX_NUM.
- CARD, 105'h0, 15 card numbers packed 7 bits each. Entry i is CARD[7i+6:7i]. Row r covers entries 5r..5r+4.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- start_game  in  1  game-running level from the keyboard controller
- num_count  in  2  keyboard press counter; any change indicates one press
- cascade_reg  in  8  [7:4] previous key, [3:0] newest key
- mark_mask  out  15  bit i set when card entry i has been called
- line  out  3  bit r set when all 5 entries of row r are marked
- bingo  out  1  all 15 entries marked; sticky
- last_num  out  7  last accepted called number
- call_count  out  7  number of accepted calls
- range_err  out  1  one-cycle pulse: pair rejected for a bad digit or out-of-range value
- dup_err  out  1  one-cycle pulse: pair rejected as already called
- overrun  out  1  one-cycle pulse: press dropped while busy

Behaviour:
- Reset (async, rstn=0):
  - All outputs go to 0.
  - 90-bit called bitmap cleared, FSM to IDLE, digit phase to 0, num_count shadow register to 0.
- Press event:
  - press = (num_count != nc_q). nc_q samples num_count every cycle.
  - A press is used only when start_game=1. This makes the start key's own press, which precedes start_game by one cycle, ignored.
- FSM states: IDLE, WAIT_D1, WAIT_D2, CHECK, COMMIT, DONE.
- IDLE:
  - Outputs hold their values.
  - start_game=1 -> WAIT_D1.
- WAIT_D1: on press -> WAIT_D2. The tens digit is sampled later from cascade_reg[7:4].
- WAIT_D2: on press:
  - If cascade_reg[3:0]==4'hA (clear key): -> WAIT_D1 with no error.
  - Otherwise register the tens and units digits, then -> CHECK.
- CHECK (1 cycle):
  - Compute val = tens*10 + units as 7-bit unsigned; no overflow is possible since 99 < 128.
  - If either digit > 9, or val==0, or val > MAX_NUM: pulse range_err -> WAIT_D1.
  - Else if called[val] is set: pulse dup_err -> WAIT_D1.
  - Else -> COMMIT.
- COMMIT (1 cycle):
  - Set called[val]; last_num <= val; call_count <= call_count+1.
  - For each i where CARD entry i == val, set mark_mask[i]; multiple matches are all set.
  - Next state: DONE if the updated mask is all ones, else WAIT_D1.
- line and bingo:
  - Registered, updated in the cycle after COMMIT, computed from mark_mask.
  - bingo is sticky until reset.
- Latency:
  - Second digit press seen at cycle T -> CHECK at T+1.
  - Error pulse at T+2, or mark_mask/last_num/call_count updated at T+2.
  - line/bingo at T+3.
- DONE: presses are ignored without overrun, and all outputs freeze.
- Busy drop: a press during CHECK or COMMIT is dropped and overrun pulses. Digit phase returns to WAIT_D1 after the current pair.
- start_game falling (reset elsewhere): any state -> IDLE on the next cycle; the partial pair is discarded and outputs are held.
- Card entry 0 or a value > MAX_NUM never matches.
- call_count saturates at MAX_NUM. It cannot be exceeded because duplicates are rejected.

Test Plan:
- Reset mid-game with 5 marks set, rstn=0 -> all outputs 0 immediately; after release, a press with start_game=1 begins in WAIT_D1.
- Start key (num_count 0->1, cascade_reg[3:0]=B, start_game rises next cycle), then digits 4,2 with CARD entry 3 = 42 -> mark_mask=15'h0008, last_num=42, call_count=1, at T+2 after the second press.
- Digits 4,2 repeated -> dup_err pulse for 1 cycle; call_count stays 1, mark_mask unchanged. Digits 9,5 -> range_err. Digits 0,0 -> range_err.
- Digit 3, then clear key A, then digits 1,7 -> 17 accepted; no error pulses.
- Call all 5 numbers of row 1 -> line=3'b010, bingo=0. Then call the remaining 10 card numbers -> line=3'b111, bingo=1, FSM in DONE; a further pair is ignored.
- Press while in CHECK (num_count toggled on consecutive cycles) -> overrun pulse; the first pair's result is still committed correctly.
